// File: rtl/lstm_bp_pkg.sv
// Shared fixed-point helpers and FSM encoding for the LSTM backprop stages.
package lstm_bp_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned FRAC_DEF  = 24;
   localparam int unsigned SAT_W     = 128;
   localparam logic [WIDTH_DEF-1:0] ONE = WIDTH_DEF'(1) << FRAC_DEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC,
      ST_DRAIN,
      ST_UPD,
      ST_DONE
   } state_e;

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] x,
                                                      input int unsigned w);
      logic signed [SAT_W-1:0] mx;
      logic signed [SAT_W-1:0] mn;
      mx = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
      mn = -(SAT_W'(1) <<< (w - 1));
      if (x > mx) begin
         return mx;
      end else if (x < mn) begin
         return mn;
      end
      return x;
   endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC, saturate.
module fxp_mul_sat
   import lstm_bp_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned FRAC  = FRAC_DEF
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic signed [WIDTH-1:0] o_p_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic signed [PW-1:0] full;
   logic signed [PW-1:0] shifted;

   always_comb begin
      full    = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
      shifted = full >>> FRAC;
      o_p_c   = WIDTH'(sat_s({{(SAT_W - PW){shifted[PW-1]}}, shifted}, WIDTH));
   end

endmodule

// File: rtl/lstm_wgrad_update.sv
// LSTM gate-matrix weight gradient accumulation over timesteps with in-place SGD update.
module lstm_wgrad_update
   import lstm_bp_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned FRAC     = FRAC_DEF,
   parameter int unsigned N_CELL   = 8,
   parameter int unsigned N_IN     = 53,
   parameter int unsigned TIMESTEP = 7,
   parameter int unsigned ADDR_D   = 6,
   parameter int unsigned ADDR_X   = 9,
   parameter int unsigned ADDR_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  i_lr,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_D-1:0] o_rd_addr_d,
   input  logic [WIDTH-1:0]  i_d,
   output logic [ADDR_X-1:0] o_rd_addr_x,
   input  logic [WIDTH-1:0]  i_x,
   output logic [ADDR_W-1:0] o_rd_addr_w,
   input  logic [WIDTH-1:0]  i_w,
   output logic              o_wr_w,
   output logic [ADDR_W-1:0] o_wr_addr_w,
   output logic [WIDTH-1:0]  o_w,
   output logic [WIDTH-1:0]  o_dw
);

   localparam int unsigned T_W = $clog2(TIMESTEP + 1);
   localparam int unsigned R_W = $clog2(N_CELL + 1);
   localparam int unsigned C_W = $clog2(N_IN + 2);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1) << FRAC;

   state_e                   state_q, state_d;
   logic [T_W-1:0]           t_q, t_d;
   logic [R_W-1:0]           r_q, r_d;
   logic [C_W-1:0]           c_q, c_d;
   logic signed [WIDTH-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]         lr_q, lr_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     wr_q, wr_d;
   logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]         w_q, w_d;
   logic [WIDTH-1:0]         dw_q, dw_d;
   logic [ADDR_D-1:0]        addr_d_q, addr_d_d;
   logic [ADDR_X-1:0]        addr_x_q, addr_x_d;
   logic [ADDR_W-1:0]        addr_w_q, addr_w_d;

   logic                     bias_col;
   logic                     last_elem;
   logic                     acc_load;
   logic                     acc_add;
   logic [WIDTH-1:0]         x_op;
   logic signed [WIDTH-1:0]  prod;
   logic signed [WIDTH-1:0]  lr_dw;
   logic signed [WIDTH:0]    sum;
   logic signed [WIDTH:0]    diff;

   assign bias_col  = (c_q == C_W'(N_IN));
   assign last_elem = (r_q == R_W'(N_CELL - 1)) && bias_col;
   assign x_op      = bias_col ? ONE_W : i_x;

   fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_dx (
      .i_a   (i_d),
      .i_b   (x_op),
      .o_p_c (prod)
   );

   fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_lr (
      .i_a   (lr_q),
      .i_b   (acc_d),
      .o_p_c (lr_dw)
   );

   // Accumulator: product of read t arrives one cycle later; the t=0 product loads.
   always_comb begin
      acc_d    = acc_q;
      sum      = {acc_q[WIDTH-1], acc_q} + {prod[WIDTH-1], prod};
      acc_load = ((state_q == ST_ACC) && (t_q == T_W'(1)))
               || ((state_q == ST_DRAIN) && (TIMESTEP == 1));
      acc_add  = ((state_q == ST_ACC) && (t_q != '0)) || (state_q == ST_DRAIN);
      if (acc_load) begin
         acc_d = prod;
      end else if (acc_add) begin
         acc_d = WIDTH'(sat_s({{(SAT_W - WIDTH - 1){sum[WIDTH]}}, sum}, WIDTH));
      end else if ((state_q == ST_UPD) || (state_q == ST_IDLE)) begin
         acc_d = '0;
      end
   end

   // Sequencing; the write payload is formed in DRAIN so it is registered into UPD.
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      r_d       = r_q;
      c_d       = c_q;
      lr_d      = lr_q;
      wr_d      = 1'b0;
      wr_addr_d = wr_addr_q;
      w_d       = w_q;
      dw_d      = dw_q;
      diff      = {i_w[WIDTH-1], i_w} - {lr_dw[WIDTH-1], lr_dw};

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACC;
               t_d     = '0;
               r_d     = '0;
               c_d     = '0;
               lr_d    = i_lr;
            end
         end
         ST_ACC: begin
            if (t_q == T_W'(TIMESTEP - 1)) begin
               state_d = ST_DRAIN;
            end else begin
               t_d = t_q + T_W'(1);
            end
         end
         ST_DRAIN: begin
            state_d   = ST_UPD;
            wr_d      = 1'b1;
            wr_addr_d = addr_w_q;
            dw_d      = acc_d;
            w_d       = WIDTH'(sat_s({{(SAT_W - WIDTH - 1){diff[WIDTH]}}, diff}, WIDTH));
         end
         ST_UPD: begin
            t_d = '0;
            if (last_elem) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ACC;
               if (bias_col) begin
                  c_d = '0;
                  r_d = r_q + R_W'(1);
               end else begin
                  c_d = c_q + C_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d   = (state_d == ST_ACC) || (state_d == ST_DRAIN) || (state_d == ST_UPD);
      done_d   = (state_d == ST_DONE);
      addr_w_d = ADDR_W'(32'(r_d) * (N_IN + 1) + 32'(c_d));
      addr_d_d = addr_d_q;
      addr_x_d = addr_x_q;
      if (state_d == ST_ACC) begin
         addr_d_d = ADDR_D'(32'(t_d) * N_CELL + 32'(r_d));
         addr_x_d = (c_d == C_W'(N_IN)) ? '0 : ADDR_X'(32'(t_d) * N_IN + 32'(c_d));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         t_q       <= '0;
         r_q       <= '0;
         c_q       <= '0;
         acc_q     <= '0;
         lr_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         w_q       <= '0;
         dw_q      <= '0;
         addr_d_q  <= '0;
         addr_x_q  <= '0;
         addr_w_q  <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         r_q       <= r_d;
         c_q       <= c_d;
         acc_q     <= acc_d;
         lr_q      <= lr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wr_q      <= wr_d;
         wr_addr_q <= wr_addr_d;
         w_q       <= w_d;
         dw_q      <= dw_d;
         addr_d_q  <= addr_d_d;
         addr_x_q  <= addr_x_d;
         addr_w_q  <= addr_w_d;
      end
   end

   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_rd_addr_d = addr_d_q;
   assign o_rd_addr_x = addr_x_q;
   assign o_rd_addr_w = addr_w_q;
   assign o_wr_w      = wr_q;
   assign o_wr_addr_w = wr_addr_q;
   assign o_w         = w_q;
   assign o_dw        = dw_q;

endmodule

// File: doc/lstm_wgrad_update.md
Name: lstm_wgrad_update

Overview:
- Weight-gradient and SGD update stage for one LSTM gate matrix. It sits directly downstream of the backpropagation datapath.
- Reads per-timestep delta-gate values from the delta-gate memory and the matching forward activations (x or h) from the activation memory.
- Accumulates dW[r][c] = sum over t of dgate[t][r]*act[t][c], including a bias column.
- Writes W_new = W_old - lr*dW back to the weight memory, one element at a time. No gradient matrix is stored.

Parameters:
- WIDTH, 32, signed fixed-point word width.
- FRAC, 24, fractional bits (Q8.24).
- N_CELL, 8, rows (cells of this layer).
- N_IN, 53, activation columns; column N_IN is the bias.
- TIMESTEP, 7, number of timesteps accumulated.
- ADDR_D, 6, delta memory address width (holds TIMESTEP*N_CELL words).
- ADDR_X, 9, activation memory address width (holds TIMESTEP*N_IN words).
- ADDR_W, 9, weight memory address width (holds N_CELL*(N_IN+1) words).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle pulse; begins a full matrix pass
- i_lr  in  WIDTH  learning rate, Q(FRAC); sampled on accepted start
- o_busy  out  1  high from the cycle after an accepted start until done
- o_done  out  1  one-cycle pulse after the final weight write
- o_rd_addr_d  out  ADDR_D  delta read address = t*N_CELL + r
- i_d  in  WIDTH  delta read data, valid 1 cycle after address
- o_rd_addr_x  out  ADDR_X  activation read address = t*N_IN + c (0 for the bias column)
- i_x  in  WIDTH  activation read data, valid 1 cycle after address
- o_rd_addr_w  out  ADDR_W  old weight address = r*(N_IN+1) + c
- i_w  in  WIDTH  old weight data, valid 1 cycle after address
- o_wr_w  out  1  weight write strobe
- o_wr_addr_w  out  ADDR_W  weight write address
- o_w  out  WIDTH  new weight value
- o_dw  out  WIDTH  gradient of the element being written (debug/monitor)

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - State returns to IDLE.
  - All outputs, addresses, the accumulator, r/c/t counters and the latched lr are cleared to 0.
  - A reset mid-pass aborts the pass: no further write and no o_done.
- States:
  - IDLE -> ACC on start. start is ignored in every other state.
  - ACC: lasts TIMESTEP cycles, t = 0..TIMESTEP-1. Each cycle issues the delta and activation addresses. o_rd_addr_w is held at the element address for the whole state.
  - DRAIN: 1 cycle; absorbs the product of the last read.
  - UPD: 1 cycle.
    - Asserts o_wr_w with o_wr_addr_w = element address.
    - o_w = sat(i_w - sat((i_lr_latched*acc)>>>FRAC)); o_dw = acc.
    - Then advance c (0..N_IN), wrapping c and incrementing r.
    - After r = N_CELL-1, c = N_IN: go to DONE; otherwise go to ACC with t = 0 and the accumulator cleared.
  - DONE: o_done = 1 for one cycle, o_busy drops in the same cycle, then IDLE.
- Pipeline:
  - Read data for the address issued in cycle k is consumed in cycle k+1.
  - The accumulator adds the product in cycles ACC[1..T-1] and DRAIN.
  - The accumulator is loaded, not added, with the t=0 product.
- Bias column (c == N_IN): the activation operand is forced to ONE = 1<<FRAC and i_x is ignored.
- Arithmetic:
  - Products are computed at full 2*WIDTH width, arithmetic-shifted right by FRAC (truncate) and saturated to the signed WIDTH range.
  - Accumulator and update subtraction saturate to [0x8000_0000, 0x7FFF_FFFF] for WIDTH=32.
- Timing: outputs o_wr_w/o_w/o_wr_addr_w/o_dw are registered. Pass length = N_CELL*(N_IN+1)*(TIMESTEP+2) cycles from ACC entry to the last UPD.
- Between writes: o_wr_w is 0 outside UPD; o_w and o_dw hold their last values.

Decomposition:
- Shared package lstm_bp_pkg:
  - WIDTH/FRAC defaults and the ONE constant.
  - Saturate-to-WIDTH function.
  - State encoding (IDLE, ACC, DRAIN, UPD, DONE).
- One sub-module fxp_mul_sat: signed multiply, >>>FRAC, saturate. Instantiated twice: delta*activation, lr*acc.

Test Plan (bench parameters N_CELL=2, N_IN=2, TIMESTEP=3; memories model 1-cycle read):
- All d=0x0100_0000 (1.0), all x=0x0080_0000 (0.5), W=0x0100_0000, lr=0x0080_0000 -> every non-bias write o_dw=0x0180_0000, o_w=0x0040_0000. Writes go to addresses 0,1,3,4.
- Same stimulus, bias columns (addresses 2,5) with W=0 -> o_dw=0x0300_0000, o_w=0xFE80_0000. Corrupting i_x during bias ACC changes nothing.
- d=x=0x7FFF_FFFF, lr=0x0100_0000, W=0x8000_0000 -> o_dw=0x7FFF_FFFF, o_w saturates to 0x8000_0000 (no wrap).
- start at cycle 0 -> exactly 6 o_wr_w pulses, spaced 5 cycles apart. o_done is a single pulse 1 cycle after the 6th write; o_busy is high for the whole interval.
- Extra start pulses while busy -> ignored, write count unchanged. rst asserted after the 3rd write -> outputs 0 immediately, no further writes, no o_done. A new start then gives a full 6-write pass.
